// File: rtl/buffer_pkg.sv
// Shared definitions for the pixel buffer and its read arbiter.
//   PIXEL_W      : width of one RGB444 buffer word
//   BUF_H, BUF_V : default frame dimensions of the buffer
//   DEPTH        : default number of words in the buffer
//   rsp_tag_t    : per-request tag carried down the response pipeline
//   port_e       : requester identity (display scan-out or auxiliary reader)
package buffer_pkg;

  localparam int PIXEL_W = 12;
  localparam int BUF_H   = 320;
  localparam int BUF_V   = 240;
  localparam int DEPTH   = BUF_H * BUF_V;

  typedef enum logic {
    PORT_DISPLAY = 1'b0,
    PORT_AUX     = 1'b1
  } port_e;

  typedef struct packed {
    logic  valid;
    port_e port;
    logic  err;
  } rsp_tag_t;

endpackage

// File: rtl/buffer_arb_starve.sv
// Starvation guard for the auxiliary port.
// Counts consecutive cycles in which port 1 asks but is refused; once the
// count reaches STARVE_LIMIT, force_port1 hands port 1 the next contested slot.
//   clk, rstn   : clock, async active-low reset
//   req1_valid  : port 1 is requesting
//   gnt1        : port 1 was granted this cycle
//   force_port1 : port 1 must win a contested cycle
module buffer_arb_starve #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic req1_valid,
  input  logic gnt1,
  output logic force_port1
);

  // A zero limit still needs a 1-bit counter; it simply never moves.
  localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt_r;

  // Saturating count of consecutive refused port 1 cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_cnt_r <= {CW{1'b0}};
    end else if (!req1_valid || gnt1) begin
      starve_cnt_r <= {CW{1'b0}};
    end else if (starve_cnt_r != LIMIT_C) begin
      starve_cnt_r <= starve_cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  assign force_port1 = (STARVE_LIMIT != 0) && (starve_cnt_r == LIMIT_C);

endmodule

// File: rtl/buffer_arbiter.sv
// Two-port read arbiter in front of the single-port, 1-cycle-latency pixel
// buffer. Port 0 (display) has strict priority; port 1 (aux) is protected
// by a starvation guard. Responses return 2 cycles after accept, in order.
//   clk, rstn                : clock, async active-low reset
//   req{0,1}_valid/addr/ready: request handshake per port
//   rsp{0,1}_valid/data/err  : registered response per port
//   mem_addr                 : read address to the buffer
//   mem_data                 : buffer read data, one cycle after mem_addr
module buffer_arbiter #(
  parameter int DEPTH        = 320 * 240,
  parameter int ADDR_WIDTH   = $clog2(DEPTH),
  parameter int DATA_WIDTH   = 12,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  output logic                  req0_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  output logic                  rsp0_err,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  output logic                  req1_ready,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic                  rsp1_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data
);

  import buffer_pkg::*;

  // One extra bit so a DEPTH equal to 2**ADDR_WIDTH still compares correctly.
  localparam int AW1 = ADDR_WIDTH + 1;
  localparam logic [AW1-1:0] DEPTH_C = AW1'(DEPTH);

  logic                  force_s;
  logic                  gnt0_s;
  logic                  gnt1_s;
  logic [ADDR_WIDTH-1:0] gnt_addr_s;
  logic                  oor_s;
  rsp_tag_t              tag1_r;

  buffer_arb_starve #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk        (clk),
    .rstn       (rstn),
    .req1_valid (req1_valid),
    .gnt1       (gnt1_s),
    .force_port1(force_s)
  );

  // Grant selection and buffer address; nothing is granted while in reset.
  always_comb begin
    gnt0_s     = 1'b0;
    gnt1_s     = 1'b0;
    gnt_addr_s = {ADDR_WIDTH{1'b0}};
    oor_s      = 1'b0;
    mem_addr   = {ADDR_WIDTH{1'b0}};
    if (rstn) begin
      if (req0_valid && !(req1_valid && force_s)) begin
        gnt0_s = 1'b1;
      end else if (req1_valid) begin
        gnt1_s = 1'b1;
      end else begin
        gnt0_s = 1'b0;
      end
    end else begin
      gnt0_s = 1'b0;
    end
    if (gnt1_s) begin
      gnt_addr_s = req1_addr;
    end else begin
      gnt_addr_s = req0_addr;
    end
    if (gnt0_s || gnt1_s) begin
      oor_s = ({1'b0, gnt_addr_s} >= DEPTH_C);
    end else begin
      oor_s = 1'b0;
    end
    // Out-of-range requests park the buffer at address 0; its data is discarded.
    if ((gnt0_s || gnt1_s) && !oor_s) begin
      mem_addr = gnt_addr_s;
    end else begin
      mem_addr = {ADDR_WIDTH{1'b0}};
    end
  end

  assign req0_ready = gnt0_s;
  assign req1_ready = gnt1_s;

  // Stage 1: tag captured at accept, aligned with the buffer's read latency.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag1_r.valid <= 1'b0;
      tag1_r.port  <= PORT_DISPLAY;
      tag1_r.err   <= 1'b0;
    end else begin
      tag1_r.valid <= gnt0_s || gnt1_s;
      tag1_r.port  <= gnt1_s ? PORT_AUX : PORT_DISPLAY;
      tag1_r.err   <= oor_s;
    end
  end

  // Stage 2: steer the returned word to the tagged port; the other port's data holds.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp0_valid <= 1'b0;
      rsp0_err   <= 1'b0;
      rsp0_data  <= {DATA_WIDTH{1'b0}};
      rsp1_valid <= 1'b0;
      rsp1_err   <= 1'b0;
      rsp1_data  <= {DATA_WIDTH{1'b0}};
    end else begin
      rsp0_valid <= tag1_r.valid && (tag1_r.port == PORT_DISPLAY);
      rsp0_err   <= tag1_r.valid && (tag1_r.port == PORT_DISPLAY) && tag1_r.err;
      rsp1_valid <= tag1_r.valid && (tag1_r.port == PORT_AUX);
      rsp1_err   <= tag1_r.valid && (tag1_r.port == PORT_AUX) && tag1_r.err;
      if (tag1_r.valid && (tag1_r.port == PORT_DISPLAY)) begin
        rsp0_data <= tag1_r.err ? {DATA_WIDTH{1'b0}} : mem_data;
      end else begin
        rsp0_data <= rsp0_data;
      end
      if (tag1_r.valid && (tag1_r.port == PORT_AUX)) begin
        rsp1_data <= tag1_r.err ? {DATA_WIDTH{1'b0}} : mem_data;
      end else begin
        rsp1_data <= rsp1_data;
      end
    end
  end

endmodule

// File: tb/tb_buffer_arbiter.sv
// Directed self-checking bench for buffer_arbiter: one instance with the
// default starvation limit, one with the guard disabled.
module tb_buffer_arbiter;

  localparam int AW = 17;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rstn;
  int            err_cnt = 0;
  int            chk_cnt = 0;

  // Instance A: STARVE_LIMIT = 8
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [AW-1:0] req0_addr, req1_addr, mem_addr;
  logic          rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [DW-1:0] rsp0_data, rsp1_data, mem_data;

  // Instance B: STARVE_LIMIT = 0
  logic          b_req0_valid, b_req1_valid, b_req0_ready, b_req1_ready;
  logic [AW-1:0] b_req0_addr, b_req1_addr, b_mem_addr;
  logic          b_rsp0_valid, b_rsp1_valid, b_rsp0_err, b_rsp1_err;
  logic [DW-1:0] b_rsp0_data, b_rsp1_data, b_mem_data;

  always #5 clk = ~clk;

  buffer_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .mem_addr(mem_addr), .mem_data(mem_data)
  );

  buffer_arbiter #(.STARVE_LIMIT(0)) dut_b (
    .clk(clk), .rstn(rstn),
    .req0_valid(b_req0_valid), .req0_addr(b_req0_addr), .req0_ready(b_req0_ready),
    .rsp0_valid(b_rsp0_valid), .rsp0_data(b_rsp0_data), .rsp0_err(b_rsp0_err),
    .req1_valid(b_req1_valid), .req1_addr(b_req1_addr), .req1_ready(b_req1_ready),
    .rsp1_valid(b_rsp1_valid), .rsp1_data(b_rsp1_data), .rsp1_err(b_rsp1_err),
    .mem_addr(b_mem_addr), .mem_data(b_mem_data)
  );

  // Buffer contents: word k holds k + 0x100.
  function automatic logic [DW-1:0] mw(input int a);
    mw = DW'(a + 256);
  endfunction

  // Synchronous-read buffer models, one per instance.
  always @(posedge clk) begin
    mem_data   <= mw(int'(mem_addr));
    b_mem_data <= mw(int'(b_mem_addr));
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle of requests on instance A at the falling edge, then settle.
  task automatic cyc(input logic v0, input int a0, input logic v1, input int a1);
    @(negedge clk);
    req0_valid = v0;
    req0_addr  = AW'(a0);
    req1_valid = v1;
    req1_addr  = AW'(a1);
    #1;
  endtask

  // Alternating table: port per slot and address.
  logic alt_port [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  int   alt_addr [4] = '{10, 11, 12, 13};

  initial begin
    rstn = 1'b0;
    req0_valid = 1'b1; req0_addr = AW'(3); req1_valid = 1'b1; req1_addr = AW'(4);
    b_req0_valid = 1'b0; b_req0_addr = '0; b_req1_valid = 1'b0; b_req1_addr = '0;
    repeat (2) @(negedge clk);
    #1;
    // Reset state
    check_eq("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_rsp", {rsp0_valid, rsp0_err, rsp1_valid, rsp1_err, 4'd0, rsp0_data, rsp1_data},
             32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    // Port 0 only, addresses 0,1,2 back to back
    for (int i = 0; i < 6; i++) begin
      cyc(i < 3, (i < 3) ? i : 0, 1'b0, 0);
      if (i < 3) begin
        check_eq("p0_ready", 32'(req0_ready), 32'd1);
        check_eq("p0_mem_addr", 32'(mem_addr), 32'(i));
      end
      if (i >= 2 && i < 5) begin
        check_eq("p0_rsp", {19'd0, rsp0_valid, rsp0_data}, {19'd0, 1'b1, mw(i - 2)});
      end
      if (i == 5) begin
        check_eq("p0_rsp_hold", {19'd0, rsp0_valid, rsp0_data}, {19'd0, 1'b0, mw(2)});
      end
      check_eq("p0_p1_quiet", {18'd0, rsp1_valid, rsp1_err, rsp1_data}, 32'd0);
    end

    // Both valid continuously with limit 8: port 1 wins every ninth cycle
    for (int i = 0; i < 29; i++) begin
      cyc(i < 27, 100 + i - i / 9, i < 27, 1000 + i / 9);
      if (i < 27) begin
        check_eq("starve_ready", {30'd0, req0_ready, req1_ready},
                 (i % 9 == 8) ? 32'd1 : 32'd2);
      end
      if (i >= 2) begin
        int j;
        j = i - 2;
        if (j % 9 == 8) begin
          check_eq("starve_rsp1", {18'd0, rsp0_valid, rsp1_valid, rsp1_data},
                   {18'd0, 1'b0, 1'b1, mw(1000 + j / 9)});
        end else begin
          check_eq("starve_rsp0", {18'd0, rsp0_valid, rsp1_valid, rsp0_data},
                   {18'd0, 1'b1, 1'b0, mw(100 + j - j / 9)});
        end
      end
    end

    // Out-of-range request on port 1
    cyc(1'b0, 0, 1'b1, 76800);
    check_eq("oor_ready", 32'(req1_ready), 32'd1);
    check_eq("oor_mem_addr", 32'(mem_addr), 32'd0);
    cyc(1'b0, 0, 1'b0, 0);
    cyc(1'b0, 0, 1'b0, 0);
    check_eq("oor_rsp", {18'd0, rsp1_valid, rsp1_err, rsp1_data}, {18'd0, 1'b1, 1'b1, 12'd0});
    check_eq("oor_p0_quiet", 32'(rsp0_valid), 32'd0);

    // Alternating single-port requests
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        cyc(!alt_port[i], alt_addr[i], alt_port[i], alt_addr[i]);
      end else begin
        cyc(1'b0, 0, 1'b0, 0);
      end
      if (i >= 2) begin
        if (alt_port[i - 2]) begin
          check_eq("alt_rsp1", {18'd0, rsp0_valid, rsp1_valid, rsp1_data},
                   {18'd0, 1'b0, 1'b1, mw(alt_addr[i - 2])});
        end else begin
          check_eq("alt_rsp0", {18'd0, rsp0_valid, rsp1_valid, rsp0_data},
                   {18'd0, 1'b1, 1'b0, mw(alt_addr[i - 2])});
        end
      end
    end

    // Reset asserted right after an accept drops the in-flight response
    cyc(1'b1, 5, 1'b0, 0);
    check_eq("mid_accept", 32'(req0_ready), 32'd1);
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = AW'(7);
    rstn = 1'b0;
    #1;
    check_eq("mid_rst_ready", 32'(req0_ready), 32'd0);
    check_eq("mid_rst_mem", 32'(mem_addr), 32'd0);
    check_eq("mid_rst_rsp", {rsp0_valid, rsp0_err, rsp1_valid, rsp1_err, 4'd0, rsp0_data, rsp1_data},
             32'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    rstn = 1'b1;
    #1;
    check_eq("mid_no_rsp_a", 32'(rsp0_valid), 32'd0);
    cyc(1'b0, 0, 1'b0, 0);
    check_eq("mid_no_rsp_b", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);

    // Guard disabled: port 1 never wins while port 0 asks
    for (int i = 0; i < 101; i++) begin
      @(negedge clk);
      b_req0_valid = (i < 100);
      b_req0_addr  = AW'(i);
      b_req1_valid = 1'b1;
      b_req1_addr  = AW'(500);
      #1;
      if (i < 100) begin
        check_eq("nolimit_ready", {30'd0, b_req0_ready, b_req1_ready}, 32'd2);
      end else begin
        check_eq("nolimit_release", {30'd0, b_req0_ready, b_req1_ready}, 32'd1);
      end
    end
    @(negedge clk);
    b_req1_valid = 1'b0;
    b_req0_valid = 1'b0;
    @(negedge clk);
    #1;
    check_eq("nolimit_rsp1", {19'd0, b_rsp1_valid, b_rsp1_data}, {19'd0, 1'b1, mw(500)});

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
